// File: rtl/pc_if.sv
// rtl/pc_if.sv - fetch-stage program-counter control/status bundle
interface pc_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             redirect;
    logic [WIDTH-1:0] redirect_target;
    logic             call;
    logic             ret;
    logic             halt;
    logic             resume;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_next;
    logic             pc_valid;
    logic             misalign_err;
    logic             ras_empty;

    modport master (
        output stall, redirect, redirect_target, call, ret, halt, resume,
        input  pc, pc_next, pc_valid, misalign_err, ras_empty
    );

    modport slave (
        input  stall, redirect, redirect_target, call, ret, halt, resume,
        output pc, pc_next, pc_valid, misalign_err, ras_empty
    );
endinterface

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - parametrised fetch PC with stall/redirect/halt and optional return-address stack (PC_RAS_EN)
module pc_unit #(
    parameter int               WIDTH        = 32,
    parameter int               INC          = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4
) (
    input logic clk,
    input logic rst,
    pc_if.slave bus
);
    localparam int               ALIGN      = $clog2(INC);
    localparam logic [WIDTH-1:0] ALIGN_MASK = {WIDTH{1'b1}} << ALIGN;
    localparam logic [WIDTH-1:0] STEP       = WIDTH'(INC);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pc_q, pc_nxt, pc_seq, ras_top;
    logic             mis_q, mis_nxt;
    logic             push, pop, ras_empty_w;

    // sequential fetch address; wraps silently at 2^WIDTH
    assign pc_seq = pc_q + STEP;

`ifdef PC_RAS_EN
    localparam int SPW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW  = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [SPW-1:0]   sp, sp_inc, sp_dec;
    logic [CW-1:0]    cnt;

    // sp points at the next free slot; the ring overwrites the oldest entry when full
    assign sp_inc      = (sp == SPW'(RAS_DEPTH - 1)) ? '0 : sp + 1'b1;
    assign sp_dec      = (sp == '0) ? SPW'(RAS_DEPTH - 1) : sp - 1'b1;
    assign ras_top     = ras_mem[sp_dec];
    assign ras_empty_w = (cnt == '0);

    // stack pointer and occupancy; reset discards any push/pop in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            sp  <= '0;
            cnt <= '0;
        end else if (push) begin
            sp <= sp_inc;
            if (cnt != CW'(RAS_DEPTH))
                cnt <= cnt + 1'b1;
        end else if (pop) begin
            sp  <= sp_dec;
            cnt <= cnt - 1'b1;
        end
    end

    // return-address storage; contents are don't-care while cnt says empty
    always_ff @(posedge clk) begin
        if (!rst && push)
            ras_mem[sp] <= pc_seq;
    end
`else
    logic unused_ras;

    assign ras_top     = '0;
    assign ras_empty_w = 1'b1;
    assign unused_ras  = ^{push, pop, ras_top, bus.call};
`endif

    // next-state and next-pc selection, in strict per-cycle priority order
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        mis_nxt   = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (bus.redirect) begin
                    pc_nxt  = bus.redirect_target & ALIGN_MASK;
                    mis_nxt = |(bus.redirect_target & ~ALIGN_MASK);
                    push    = bus.call;
                end else if (bus.ret && !ras_empty_w) begin
                    pc_nxt = ras_top;
                    pop    = 1'b1;
                end else if (!bus.halt && !bus.stall) begin
                    pc_nxt = pc_seq;
                end
                // halt still lets a same-cycle redirect or pop land first
                if (bus.halt)
                    state_nxt = HALT;
            end
            HALT: begin
                if (bus.resume)
                    state_nxt = RUN;
            end
            default: state_nxt = BOOT;
        endcase
    end

    // state, pc and the one-cycle misalignment flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
            pc_q  <= RESET_VECTOR;
            mis_q <= 1'b0;
        end else begin
            state <= state_nxt;
            pc_q  <= pc_nxt;
            mis_q <= mis_nxt;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_next      = pc_nxt;
    assign bus.pc_valid     = (state == RUN);
    assign bus.misalign_err = mis_q;
    assign bus.ras_empty    = ras_empty_w;
endmodule
